chan_fifo: RTL

CHAN_FIFO -- requirements
Module: chan_fifo

---
 rtl/chan_fifo.sv | 85 ++++++++
 1 files changed

// File: rtl/chan_fifo.sv
// chan_fifo: DEPTH-entry ready/valid channel FIFO.
// Every output is a flop. The head word is kept in a dedicated output register
// so that odata never depends combinationally on any input.
module chan_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AFULL = DEPTH - 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             idata,
   input  logic                         ivalid,
   output logic                         iready,
   output logic [WIDTH-1:0]             odata,
   output logic                         ovalid,
   input  logic                         oready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         afull
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = $clog2(DEPTH);

   // circular storage; the word at rptr is also mirrored on odata
   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW-1:0]    wptr_n;
   logic [AW-1:0]    rptr_n;
   logic             push;
   logic             pop;
   logic             load_head;
   logic [CW-1:0]    count_n;
   logic [WIDTH-1:0] odata_n;

   // handshake decode, occupancy and next head word
   always_comb begin
      push      = ivalid && iready;
      pop       = ovalid && oready;
      count_n   = count + CW'(push) - CW'(pop);
      wptr_n    = push ? AW'(wptr + 1'b1) : wptr;
      rptr_n    = pop  ? AW'(rptr + 1'b1) : rptr;
      // head register reloads when the current head leaves or when it is empty
      load_head = pop || !ovalid;
      odata_n   = odata;
      if (load_head) begin
         // no older word remains at rptr_n: the incoming word becomes the head
         if (push && (wptr == rptr_n)) begin
            odata_n = idata;
         end else begin
            odata_n = mem[rptr_n];
         end
      end
   end

   // control state; reset dominates flush, both discard any push/pop
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         ovalid <= 1'b0;
         iready <= 1'b1;
         afull  <= 1'b0;
      end else begin
         wptr   <= wptr_n;
         rptr   <= rptr_n;
         count  <= count_n;
         ovalid <= (count_n != '0);
         iready <= (count_n < CW'(DEPTH));
         afull  <= (count_n >= CW'(AFULL));
         odata  <= odata_n;
      end
   end

   // storage write; array contents are never reset
   always_ff @(posedge clock) begin
      if (push && !reset && !flush) begin
         mem[wptr] <= idata;
      end
   end

endmodule
